// File: rtl/ram_capture_drive_if.sv
// Bus bundle for ram_capture_drive: capture control, write status and the random read port.
interface ram_capture_drive_if #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 9
);
    logic              Start;
    logic              En;
    logic [DATA_W-1:0] Din;
    logic              Busy;
    logic              Done;
    logic [ADDR_W-1:0] Wr_addr;
    logic [ADDR_W-1:0] Rd_addr;
    logic [DATA_W-1:0] Rd_q;

    modport master (
        output Start, En, Din, Rd_addr,
        input  Busy, Done, Wr_addr, Rd_q
    );

    modport slave (
        input  Start, En, Din, Rd_addr,
        output Busy, Done, Wr_addr, Rd_q
    );
endinterface

// File: rtl/ram_capture_drive.sv
// Captures a DEPTH-sample block into internal RAM on En strobes, with a registered read port.
// Define CAPTURE_WRAP_EN for circular pre-trigger capture (Start in CAPTURE freezes the block).
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for Start; En ignored
// S_CAPTURE | writing Din to RAM[Wr_addr] on each En
// S_DONE    | block complete (or frozen in wrap mode); En ignored
module ram_capture_drive #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 315,
    parameter int ADDR_W = 9
) (
    input  logic                 clk_50M,
    input  logic                 Rst_n,
    ram_capture_drive_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] SAT_ADDR   = ADDR_W'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_WIDE = (ADDR_W + 1)'(DEPTH);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] rd_q_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic              rd_in_range;

    // Start always wins over En, so a same-cycle Start never writes.
    assign wr_en       = Rst_n && (state_q == S_CAPTURE) && bus.En && !bus.Start;
    assign rd_in_range = ({1'b0, bus.Rd_addr} < DEPTH_WIDE);

    always_ff @(posedge clk_50M) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.Start) begin
                        state_q   <= S_CAPTURE;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        wr_addr_q <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (bus.Start) begin
`ifdef CAPTURE_WRAP_EN
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`else
                        wr_addr_q <= '0;
`endif
                    end else if (bus.En) begin
                        if (wr_addr_q == LAST_ADDR) begin
`ifdef CAPTURE_WRAP_EN
                            wr_addr_q <= '0;
`else
                            wr_addr_q <= SAT_ADDR;
                            state_q   <= S_DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
`endif
                        end else begin
                            wr_addr_q <= wr_addr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // RAM is deliberately left out of reset so a captured block survives an abort.
    always_ff @(posedge clk_50M) begin
        if (wr_en) begin
            mem[wr_addr_q] <= bus.Din;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!Rst_n) begin
            rd_q_q <= '0;
        end else if (rd_in_range) begin
            rd_q_q <= mem[bus.Rd_addr];
        end else begin
            rd_q_q <= '0;
        end
    end

    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Wr_addr = wr_addr_q;
    assign bus.Rd_q    = rd_q_q;

endmodule

// File: doc/ram_capture_drive.md
Name: ram_capture_drive

Overview:
- Writer-side counterpart of the sequential ROM sample source in the kalman path.
- Captures a fixed-length block of filter output samples into an internal RAM, one sample per En strobe.
- Provides a 1-cycle-latency random read port so the captured block can be dumped or compared against the source waveform.
- Default depth of 315 samples matches one full period of the ROM stimulus, so capture and source stay index-aligned.

Parameters:
- DATA_W, 9, sample width in bits.
- DEPTH, 315, number of samples per capture block.
- ADDR_W, 9, address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk_50M  input  1  system clock; all logic on the rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- Start  input  1  single-cycle pulse that arms or restarts a capture.
- En  input  1  sample-valid strobe; Din is written on cycles where En=1 in CAPTURE.
- Din  input  DATA_W  sample data.
- Busy  output  1  high while in CAPTURE.
- Done  output  1  high in DONE; block complete.
- Wr_addr  output  ADDR_W  next write address, equal to the number of samples captured so far.
- Rd_addr  input  ADDR_W  read address.
- Rd_q  output  DATA_W  read data, registered.

Behaviour:
- Reset is synchronous: sampled only at a clk_50M edge with Rst_n=0. It forces state=IDLE, Busy=0, Done=0, Wr_addr=0, Rd_q=0. RAM contents are not cleared.
- A reset during CAPTURE aborts the capture; the next Start begins at address 0.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - Start=1 -> CAPTURE with Wr_addr=0.
  - En is ignored, including an En that arrives in the same cycle as Start. The first write happens on the earliest En after entering CAPTURE.
- CAPTURE:
  - En=1 writes RAM[Wr_addr]=Din.
  - If Wr_addr < DEPTH-1, Wr_addr increments by 1.
  - If Wr_addr == DEPTH-1, that final sample is written, Wr_addr becomes DEPTH (saturates), and state -> DONE on the next cycle.
  - En=0 holds all state.
- Start=1 in CAPTURE restarts the capture: Wr_addr=0, and no write occurs that cycle even if En=1.
- DONE:
  - Done=1 and Busy=0.
  - En is ignored.
  - Start=1 -> CAPTURE with Wr_addr=0; Done drops in the same cycle Busy rises.
- Outputs:
  - Busy and Done are registered and decoded from state.
  - They are never high simultaneously.
- Read port:
  - Rd_q <= RAM[Rd_addr] on every edge, so data is valid 1 cycle after Rd_addr is presented.
  - Reads are permitted in any state.
  - If Rd_addr >= DEPTH, Rd_q <= 0.
  - A same-cycle read and write to one address returns the old data (read-before-write).
- Storage: an inferred single-clock simple dual-port RAM, DEPTH x DATA_W. There is no arithmetic on the data path.

Optional Feature:
- Macro: CAPTURE_WRAP_EN.
- When defined (circular pre-trigger mode):
  - In CAPTURE, a write at Wr_addr == DEPTH-1 wraps Wr_addr to 0 and the FSM stays in CAPTURE.
  - A Start pulse in CAPTURE freezes the capture: state -> DONE, with Wr_addr holding the oldest-sample index.
  - Start in IDLE or DONE behaves as in the base mode.
- When undefined: the base behaviour above applies (saturate at DEPTH, go to DONE, and Start in CAPTURE restarts).

Test Plan:
- Reset mid-capture: Start, 10 En writes, then Rst_n=0 for 1 cycle -> Busy=0, Done=0, Wr_addr=0, Rd_q=0. RAM[0..9] still reads back the previously written values.
- Full block: Start, then 315 En pulses with Din=address -> Done rises 1 cycle after the 315th write and Wr_addr=315. Reading Rd_addr=0..314 returns 0..314 at 1-cycle latency; Rd_addr=400 returns 0.
- Gapped strobes: En asserted every 3rd cycle with Din=9'h1AA, 9'h055, ... -> Wr_addr advances only on En cycles. Data is packed contiguously at addresses 0,1,2,...
- Same-cycle boundaries:
  - Start with En=1 in IDLE -> nothing written at address 0, Wr_addr=0.
  - Start with En=1 at Wr_addr=100 in CAPTURE -> Wr_addr=0 and RAM[100] unchanged.
- Read-before-write: in one cycle, write Din=9'h0F0 to address 5 (old value 9'h00F) while Rd_addr=5 -> Rd_q=9'h00F next cycle, then 9'h0F0 on the following read.
- CAPTURE_WRAP_EN: 400 writes with Din=write index mod 512, then Start -> Done=1 and Wr_addr=85. RAM[85]=85 (the oldest sample) and RAM[84]=399.
